muldiv_ctrl: RTL
================

# muldiv_ctrl

Iterative multiply/divide sequencer owning the HI/LO register pair of the pipelined MIPS core. It accepts a mult/multu/div/divu issued from the Execute stage and runs a WIDTH-cycle shift-add or restoring-divide sequence. It writes the corrected 64-bit result into HI/LO and raises a decode-stage stall while busy, so that later mult/div/mfhi/mflo instructions wait.

## Interface
- WIDTH, 32, operand width; also the number of RUN iterations (HI/LO each WIDTH bits)
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- startE  in  1  Execute-stage mult/div valid (already gated by flushE/hlwriteE upstream)
- opE  in  2  00 mult, 01 multu, 10 div, 11 divu
- srcaE  in  WIDTH  rs operand (multiplicand / dividend)
- srcbE  in  WIDTH  rt operand (multiplier / divisor)
- mdreqD  in  1  Decode-stage instruction is mult/div/mfhi/mflo
- busy  out  1  state != IDLE
- stallD  out  1  busy & mdreqD (combinational)
- done  out  1  one-cycle pulse after HI/LO update
- divzero  out  1  valid with done; 1 when a div/divu had srcbE == 0
- hi  out  WIDTH  architectural HI
- lo  out  WIDTH  architectural LO

## Operation
- States: IDLE, RUN, FIX. Registered 2-bit state, counter of clog2(WIDTH) bits.
- IDLE & startE: latch opcode, sign of a (sa) and sign of b (sb), and magnitudes.
  - Signed ops use |a|, |b|.
  - Unsigned ops use raw values with sa = sb = 0.
  - Clear counter.
  - Next state is RUN, except a divide with srcbE == 0, which goes directly to FIX with the dz flag set.
- RUN, multiply: one shift-add step per cycle on a 2*WIDTH accumulator, LSB-first.
- RUN, divide: one restoring step per cycle. Shift {rem, quo} left by 1. If rem >= divisor, subtract and set quo bit 0.
- RUN: counter increments each cycle; on the edge where counter == WIDTH-1, next state is FIX.
- FIX, multiply: {hi, lo} <= (sa ^ sb) ? -product : product. Negation is 2*WIDTH-bit two's complement.
- FIX, divide: lo <= quotient, negated if sa ^ sb; hi <= remainder, negated if sa.
  - Overflow case -2^(WIDTH-1) / -1: lo = 0x80000000, hi = 0. No exception.
- FIX, divide by zero: hi <= srcaE as latched, lo <= all ones, divzero = 1.
- FIX: done <= 1, next state is IDLE.
- startE while busy: ignored. The pipeline guarantees this never happens via stallD; it is asserted in the bench.
- hi/lo change only in FIX. mfhi/mflo read them directly; stallD blocks reads until the update is complete.

## Timing
- Reset values: state IDLE, counter 0, hi 0, lo 0, done 0, divzero 0, busy 0. stallD = 0 regardless of mdreqD.
- startE is sampled at edge E0, and busy rises after E0.
- Normal op: RUN occupies edges E1..E(WIDTH) and FIX is edge E(WIDTH+1).
  - hi/lo and done are valid after E(WIDTH+1).
  - busy stays high for WIDTH+1 cycles: 33 for WIDTH=32.
- Divide by zero: FIX at E1; busy for 1 cycle; result after E1.
- done and divzero are high for exactly one cycle, the cycle after FIX. divzero is 0 whenever done is 0.
- Back-to-back: startE in the same cycle that done is high is accepted, since state is IDLE.
- Reset asserted mid-RUN or mid-FIX takes effect immediately (async): busy 0, and hi/lo cleared to 0, not preserved.

## Test plan
- mult 0xFFFFFFFE (-2) × 0x00000003: after 33 cycles hi=0xFFFFFFFF, lo=0xFFFFFFFA; done pulses once; busy high for exactly 33 cycles.
- multu 0xFFFFFFFF × 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- div -7 / 2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); divu 100 / 7 -> lo=14, hi=2.
- div 0x12345678 / 0: busy for 1 cycle, then hi=0x12345678, lo=0xFFFFFFFF, divzero=1 with done.
- Hazard and edge cases:
  - mdreqD held high during an op: stallD=1 for all 33 busy cycles, then 0.
  - startE presented with done high: accepted.
  - div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Reset pulse at RUN cycle 10 of a mult: busy drops immediately, hi=lo=0. A following mult 5×6 then yields lo=30, hi=0.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - iterative mult/div sequencer owning the HI/LO pair
// Shift-add multiply and restoring divide on magnitudes, sign-corrected in FIX.
module muldiv_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             startE,
   input  logic [1:0]       opE,
   input  logic [WIDTH-1:0] srcaE,
   input  logic [WIDTH-1:0] srcbE,
   input  logic             mdreqD,
   output logic             busy,
   output logic             stallD,
   output logic             done,
   output logic             divzero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] FIX  = 2'd2;

   logic [1:0]         state;
   logic [CW-1:0]      cnt;
   logic               isDiv, sa, sb, dz;
   logic [WIDTH-1:0]   magA, magB, aRaw;
   logic [2*WIDTH-1:0] acc;

   logic               signedOp, startDz;
   logic [WIDTH-1:0]   absA, absB;
   logic [WIDTH:0]     mulSum, remSh;
   logic [WIDTH-1:0]   remSub, quo, rem;
   logic               geq;
   logic [2*WIDTH-1:0] mulNext, divNext, negAcc;

   always_comb begin
      signedOp = ~opE[0];
      absA     = (signedOp && srcaE[WIDTH-1]) ? -srcaE : srcaE;
      absB     = (signedOp && srcbE[WIDTH-1]) ? -srcbE : srcbE;
      startDz  = opE[1] && (srcbE == '0);
      // Multiplier sits in the low half and is consumed LSB-first as the product grows above it.
      mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, magA} : '0);
      mulNext  = {mulSum, acc[WIDTH-1:1]};
      // Shifted remainder can exceed WIDTH bits; the difference always fits once geq holds.
      remSh    = acc[2*WIDTH-1:WIDTH-1];
      geq      = remSh >= {1'b0, magB};
      remSub   = remSh[WIDTH-1:0] - magB;
      divNext  = {geq ? remSub : remSh[WIDTH-1:0], acc[WIDTH-2:0], geq};
      negAcc   = -acc;
      quo      = acc[WIDTH-1:0];
      rem      = acc[2*WIDTH-1:WIDTH];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         isDiv   <= 1'b0;
         sa      <= 1'b0;
         sb      <= 1'b0;
         dz      <= 1'b0;
         magA    <= '0;
         magB    <= '0;
         aRaw    <= '0;
         acc     <= '0;
         hi      <= '0;
         lo      <= '0;
         done    <= 1'b0;
         divzero <= 1'b0;
      end else begin
         done    <= 1'b0;
         divzero <= 1'b0;
         case (state)
            IDLE: begin
               if (startE) begin
                  isDiv <= opE[1];
                  sa    <= signedOp & srcaE[WIDTH-1];
                  sb    <= signedOp & srcbE[WIDTH-1];
                  dz    <= startDz;
                  magA  <= absA;
                  magB  <= absB;
                  aRaw  <= srcaE;
                  cnt   <= '0;
                  acc   <= opE[1] ? {{WIDTH{1'b0}}, absA} : {{WIDTH{1'b0}}, absB};
                  state <= startDz ? FIX : RUN;
               end
            end
            RUN: begin
               acc <= isDiv ? divNext : mulNext;
               cnt <= cnt + 1'b1;
               if (cnt == CW'(WIDTH-1))
                  state <= FIX;
            end
            FIX: begin
               if (dz) begin
                  hi      <= aRaw;
                  lo      <= '1;
                  divzero <= 1'b1;
               end else if (isDiv) begin
                  lo <= (sa ^ sb) ? -quo : quo;
                  hi <= sa ? -rem : rem;
               end else begin
                  {hi, lo} <= (sa ^ sb) ? negAcc : acc;
               end
               done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy   = (state != IDLE);
   assign stallD = busy & mdreqD;

endmodule
